// File: rtl/rf_writeback_arbiter_if.sv
// Register-file write-side bundle: pipeline writeback, long-latency result stream,
// register-file write port and hazard/stall feedback.
interface rf_writeback_arbiter_if;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        i_ll_valid;
  logic        o_ll_ready;
  logic [4:0]  i_ll_rd;
  logic [31:0] i_ll_data;
  logic        o_rd_wen;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata;
  logic [31:0] o_ll_pending;
  logic        o_stall_req;

  modport slave (
    input  i_wb_valid, i_wb_rd, i_wb_data,
    input  i_ll_valid, i_ll_rd, i_ll_data,
    output o_ll_ready, o_rd_wen, o_rd_waddr, o_rd_wdata, o_ll_pending, o_stall_req
  );

  modport master (
    output i_wb_valid, i_wb_rd, i_wb_data,
    output i_ll_valid, i_ll_rd, i_ll_data,
    input  o_ll_ready, o_rd_wen, o_rd_waddr, o_rd_wdata, o_ll_pending, o_stall_req
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Merges the non-stallable pipeline writeback and a FIFO-buffered long-latency
// result stream onto one registered register-file write port.
module rf_writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rf_writeback_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [SW-1:0] starve_reg;
  logic [4:0]    rd_mem   [DEPTH];
  logic [31:0]   data_mem [DEPTH];

  logic        rd_wen_reg;
  logic [4:0]  rd_waddr_reg;
  logic [31:0] rd_wdata_reg;

  logic ll_ready, fifo_empty, wb_win, pop, push;
  logic [31:0] slot_mask [DEPTH];
  logic [31:0] pending_next;

  assign ll_ready   = (count_reg < CW'(DEPTH));
  assign fifo_empty = (count_reg == '0);
  assign wb_win     = bus.i_wb_valid && (bus.i_wb_rd != 5'd0);
  assign pop        = !wb_win && !fifo_empty;
  // x0 results complete the handshake but are never stored.
  assign push       = bus.i_ll_valid && ll_ready && (bus.i_ll_rd != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_mask[gi] = valid_reg[gi] ? (32'd1 << rd_mem[gi]) : 32'd0;
    end
  endgenerate

  always_comb begin
    pending_next = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      pending_next = pending_next | slot_mask[i];
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      rd_mem[wr_ptr_reg]   <= bus.i_ll_rd;
      data_mem[wr_ptr_reg] <= bus.i_ll_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      valid_reg    <= '0;
      starve_reg   <= '0;
      rd_wen_reg   <= 1'b0;
      rd_waddr_reg <= 5'd0;
      rd_wdata_reg <= 32'd0;
    end else begin
      if (pop) begin
        valid_reg[rd_ptr_reg] <= 1'b0;
        rd_ptr_reg            <= rd_ptr_reg + 1'b1;
      end
      if (push) begin
        valid_reg[wr_ptr_reg] <= 1'b1;
        wr_ptr_reg            <= wr_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      // Only a WB win over a waiting head counts as starvation.
      if (!fifo_empty && wb_win) begin
        if (starve_reg != SW'(STARVE_LIMIT)) starve_reg <= starve_reg + 1'b1;
      end else begin
        starve_reg <= '0;
      end

      rd_wen_reg <= wb_win || pop;
      if (wb_win) begin
        rd_waddr_reg <= bus.i_wb_rd;
        rd_wdata_reg <= bus.i_wb_data;
      end else if (pop) begin
        rd_waddr_reg <= rd_mem[rd_ptr_reg];
        rd_wdata_reg <= data_mem[rd_ptr_reg];
      end
    end
  end

  assign bus.o_ll_ready   = ll_ready;
  assign bus.o_rd_wen     = rd_wen_reg;
  assign bus.o_rd_waddr   = rd_waddr_reg;
  assign bus.o_rd_wdata   = rd_wdata_reg;
  assign bus.o_ll_pending = pending_next;
  assign bus.o_stall_req  = (starve_reg == SW'(STARVE_LIMIT));
endmodule
